// File: rtl/mul_seq_32b.sv
// Sequential 32x32->64 unsigned shift-add multiplier sharing one ripple adder.
// Optional build macro: MUL_ZERO_BYPASS_EN (zero operand skips the iteration loop).

// fa_32b: 32-bit ripple-carry adder.
// Latency: combinational.
// Backpressure: none.
module fa_32b (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);
   logic [32:0] cy;

   assign cy[0] = cin;

   for (genvar i = 0; i < 32; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ cy[i];
      assign cy[i+1]  = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
   end

   assign cout = cy[32];
endmodule

// mul_seq_32b: multi-cycle multiply unit, one operand pair per start.
// Latency: done 32 cycles after the accepting edge; issue interval 34 cycles.
// Backpressure: start is only sampled in idle; requests while busy are dropped.
module mul_seq_32b (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] prod
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t      state;
   state_t      state_n;
   logic        load;
   logic        step;

   logic [31:0] mcand;
   logic [31:0] hi;
   logic        c;
   logic [31:0] mq;
   logic [5:0]  cnt;

   logic [31:0] sum;
   logic        cout;
   logic [64:0] acc;
   logic [64:0] nxt;

`ifdef MUL_ZERO_BYPASS_EN
   logic        zero_op;
   assign zero_op = (a == 32'd0) || (b == 32'd0);
`endif

   fa_32b u_fa (
      .a    (hi),
      .b    (mcand),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   // c is zero after every load and every shift, so the no-add path
   // still matches shifting in a zero above hi.
   assign acc = mq[0] ? {cout, sum, mq} : {c, hi, mq};
   assign nxt = acc >> 1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = S_BUSY;
`ifdef MUL_ZERO_BYPASS_EN
               if (zero_op) begin
                  state_n = S_DONE;
               end
`endif
            end
         end
         S_BUSY: begin
            step = 1'b1;
            if (cnt == 6'd31) begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand <= 32'd0;
         hi    <= 32'd0;
         c     <= 1'b0;
         mq    <= 32'd0;
         cnt   <= 6'd0;
         prod  <= 64'd0;
      end else begin
         if (load) begin
            mcand <= a;
            mq    <= b;
            hi    <= 32'd0;
            c     <= 1'b0;
            cnt   <= 6'd0;
`ifdef MUL_ZERO_BYPASS_EN
            if (zero_op) begin
               prod <= 64'd0;
            end
`endif
         end
         if (step) begin
            {c, hi, mq} <= nxt;
            cnt         <= cnt + 6'd1;
            if (cnt == 6'd31) begin
               prod <= nxt[63:0];
            end
         end
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);
endmodule

// File: doc/mul_seq_32b.md
# mul_seq_32b

Sequential 32x32 to 64-bit unsigned shift-add multiplier controller that time-multiplexes a single `fa_32b` ripple adder over 32 iterations. It accepts one operand pair per start pulse, sequences adder use and accumulator shifts with a small FSM, and reports a registered 64-bit product with a one-cycle done pulse. It sits beside the lab ALU as the multi-cycle multiply unit.

## Interface
Parameters:
- none; operand width is fixed at 32 bits by the `fa_32b` instance.

Ports:
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  reset, synchronous, active-low, sampled on `clk` rising edge.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  32  multiplicand, unsigned; captured when `start` is accepted.
- `b`  input  32  multiplier, unsigned; captured when `start` is accepted.
- `busy`  output  1  high in BUSY and DONE.
- `done`  output  1  one-cycle pulse; high only in DONE.
- `prod`  output  64  product; valid while `done`=1, held until the next accepted `start`.

## Operation
- Internal registers:
  - `mcand[31:0]`
  - `hi[31:0]`
  - `c` (adder carry)
  - `mq[31:0]` (multiplier / low product)
  - `cnt[5:0]`
- FSM states:
  - IDLE: `start`=1 loads `mcand`=`a`, `mq`=`b`, `hi`=0, `c`=0 and `cnt`=0, then goes to BUSY. `start`=0 stays in IDLE.
  - BUSY: one iteration per cycle.
    - `fa_32b` is driven with inputs `hi` and `mcand`, `cin`=0, producing `{cout,sum}`.
    - If `mq[0]`=1, `{c,hi,mq} <= {cout,sum,mq} >> 1`. Otherwise `{c,hi,mq} <= {1'b0,hi,mq} >> 1`.
    - `cnt` increments each iteration. After the iteration with `cnt`=31, the FSM goes to DONE.
  - DONE: `prod`=`{hi,mq}` (registered on entry) and `done`=1. Goes unconditionally to IDLE on the next edge.
- `start` is ignored in BUSY and DONE. It is not queued.
- A new `start` in the IDLE cycle directly after DONE is accepted normally, giving back-to-back operations.
- `prod` does not change during BUSY. It updates only on entry to DONE.
- The adder is the only arithmetic resource. No `*` operator is used.

## Timing
- Reset (`rst_n`=0 at an edge), from any state including mid-BUSY:
  - state goes to IDLE;
  - `busy`=0, `done`=0, `prod`=0;
  - all internal registers are cleared;
  - the in-flight operation is discarded, with no `done` pulse.
- `rst_n`=0 takes precedence over `start` on the same edge.
- Latency: `start` is accepted at edge E0, BUSY iterations occur at E1..E32, and `done`=1 and `prod` are valid in the cycle after E32.
- Accept-to-done latency is 32 cycles. Minimum issue interval is 34 cycles: 32 BUSY + 1 DONE + 1 IDLE.
- `busy` rises in the cycle after E0 and falls in the cycle after DONE.
- The adder path is combinational within one BUSY cycle. There is no multicycle path.
- Width boundary: the carry out of `fa_32b` is always shifted into `hi[31]`, so no overflow is possible. The maximum product is 0xFFFFFFFE_00000001.

## Configuration
- `MUL_ZERO_BYPASS_EN` defined: in IDLE, if `start`=1 and (`a`==0 or `b`==0), the FSM goes directly to DONE with `prod`=0.
  - `done` is high in the cycle after E0, and BUSY is skipped.
  - Nonzero operands behave exactly as without the macro.
- `MUL_ZERO_BYPASS_EN` undefined: zero operands take the full 32-cycle path and yield `prod`=0.

## Test plan
- Reset, then `a`=1100, `b`=2000, `start` pulse:
  - `done` pulses exactly 32 cycles after the accept edge;
  - `prod`=64'd2200000 (0x2191C0);
  - `busy` is high for 33 cycles.
- `a`=0xFFFFFFFF, `b`=0xFFFFFFFF: `prod`=0xFFFFFFFE_00000001, which checks carry capture on every iteration.
- `a`=2100, `b`=2500, with `start` held high for the whole operation:
  - the first product is 5250000;
  - a second operation starts in the IDLE cycle after DONE;
  - the operand change during BUSY has no effect.
- `a`=0, `b`=12345:
  - without the macro, `prod`=0 after 32 cycles;
  - with `MUL_ZERO_BYPASS_EN`, `done` is high in the cycle after accept with `prod`=0.
- Start `a`=7, `b`=9, then assert `rst_n`=0 at cycle 10 of BUSY:
  - all outputs are 0 the next cycle, with no `done` pulse;
  - a fresh start after release gives `prod`=63.
- Random sweep of 1000 operand pairs, compared against a 64-bit reference product, including `a`=1 and `b`=0x80000000 (expected 0x00000000_80000000).
